load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-port load/store unit with parked address bus and read-modify-write sub-word stores
module load_store_unit #(
  parameter logic [31:0] PARK_ADDR = 32'h0000_0FF0,
  parameter logic [31:0] MEM_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] am2,
  output logic [31:0] dm3,
  output logic        rw,
  input  logic [31:0] dm2
);

  typedef enum logic [2:0] {IDLE, PARK, RD, MPARK, WR, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_q;

  logic [2:0]  nbytes;
  logic [32:0] last_byte;
  logic        bad_req;

  // Range check uses 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    last_byte = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;
    bad_req   = (req_size == 2'b11) || (last_byte > {1'b0, MEM_LIMIT});
  end

  assign req_ready = (state == IDLE) && !reset;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic sg);
    case (sz)
      2'b00:   return {{24{sg & d[7]}}, d[7:0]};
      2'b01:   return {{16{sg & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'b00) return {old[31:8], wd[7:0]};
    return {old[31:16], wd[15:0]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      am2        <= PARK_ADDR;
      rw         <= 1'b0;
      dm3        <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          am2 <= PARK_ADDR;
          rw  <= 1'b0;
          if (req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (bad_req) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state <= PARK;
            end
          end
        end
        PARK: begin
          am2 <= addr_q;
          if (we_q && size_q == 2'b10) begin
            state <= WR;
            // A store aimed at the park address is never driven as a write.
            rw    <= (addr_q != PARK_ADDR);
            dm3   <= wdata_q;
          end else begin
            state <= RD;
            rw    <= 1'b0;
          end
        end
        RD: begin
          rd_q <= dm2;
          am2  <= PARK_ADDR;
          if (!we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extend(dm2, size_q, signed_q);
          end else begin
            state <= MPARK;
          end
        end
        MPARK: begin
          state <= WR;
          am2   <= addr_q;
          rw    <= (addr_q != PARK_ADDR);
          dm3   <= merge(rd_q, wdata_q, size_q);
        end
        WR: begin
          state      <= RESP;
          am2        <= PARK_ADDR;
          rw         <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          am2   <= PARK_ADDR;
          rw    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a little-endian byte memory model
module tb_load_store_unit;

  localparam logic [31:0] PARK = 32'h0000_0FF0;
  localparam int MSZ = 4104;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, am2, dm3, dm2;
  logic        rw;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .am2(am2), .dm3(dm3), .rw(rw), .dm2(dm2)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [0:MSZ-1];

  function automatic logic [7:0] mb(input logic [31:0] a);
    return (a < MSZ) ? mem[a] : 8'h00;
  endfunction

  always_comb dm2 = {mb(am2 + 32'd3), mb(am2 + 32'd2), mb(am2 + 32'd1), mb(am2)};

  always @(posedge clk) begin
    if (rw) begin
      for (int k = 0; k < 4; k++)
        if (am2 + k < MSZ) mem[am2 + k] <= dm3[8*k +: 8];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rw_cycles = 0;
  bit   am2_moved = 0;
  bit   fresh = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every cycle a response is presented, pops on handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rw) begin
      rw_cycles++;
      checks++;
      if (am2 == PARK) begin
        errors++;
        $display("FAIL rw_at_park: got am2 %h with rw=1", am2);
      end
    end
    if (am2 != PARK) am2_moved = 1;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata %h err %b, expected no response", resp_rdata, resp_err);
      end else begin
        e = exp_q[0];
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        if (fresh) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        fresh = 0;
        if (resp_ready) begin
          void'(exp_q.pop_front());
          fresh = 1;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el,
                       input int erw, input int stall);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_before", 32'(req_ready), 32'd1);
    resp_ready = (stall == 0);
    req_valid  = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    rw_cycles = 0;
    am2_moved = 0;
    e.rdata = er; e.err = ee; e.lat = el; e.acc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0;
    if (stall > 0) begin
      n = 0;
      while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        chk("stall_resp_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_stall_valid", 32'(resp_valid), 32'd0);
      chk("post_stall_idle", 32'(req_ready), 32'd1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response for addr %h, expected one", a);
      exp_q.delete();
      fresh = 1;
    end
    @(negedge clk);
    chk("rw_cycles", 32'(rw_cycles), 32'(erw));
    chk("am2_moved", 32'(am2_moved), 32'(!ee));
  endtask

  function automatic logic [31:0] mword(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    #3;
    chk("rst_am2", am2, PARK);
    chk("rst_rw", 32'(rw), 32'd0);
    chk("rst_dm3", dm3, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_req_ready", 32'(req_ready), 32'd1);

    // word store / word load
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1, 0);
    chk("mem_100", 32'(mem[32'h100]), 32'hEF);
    chk("mem_101", 32'(mem[32'h101]), 32'hBE);
    chk("mem_102", 32'(mem[32'h102]), 32'hAD);
    chk("mem_103", 32'(mem[32'h103]), 32'hDE);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 0);

    // byte store with read-modify-write, then signed/unsigned byte loads
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345680, 32'h0, 1'b0, 5, 1, 0);
    chk("mem_word_100", mword(32'h100), 32'hDEAD80EF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0, 3, 0, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h00000080, 1'b0, 3, 0, 0);

    // halfword store over 0xAAAAAAAA
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'hAAAAAAAA, 32'h0, 1'b0, 3, 1, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h200, 32'hFFFF1234, 32'h0, 1'b0, 5, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hAAAA1234, 1'b0, 3, 0, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h00001234, 1'b0, 3, 0, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'hFFFFAAAA, 1'b0, 3, 0, 0);

    // illegal size and range boundaries
    issue(1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFE,  32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b1, 2'b10, 1'b0, 32'hFFE,  32'h5A5A5A5A, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFD,  32'h0, 32'h0, 1'b0, 3, 0, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b0, 3, 0, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 1, 0, 0);

    // response back-pressure
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0, 3, 0, 4);

    // reset in the middle of a write
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h11223344, 32'h0, 1'b0, 3, 1, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_rw_high", 32'(rw), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_rw_drop", 32'(rw), 32'd0);
    chk("reset_am2", am2, PARK);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_req_ready", 32'(req_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("aborted_no_write", mword(32'h300), 32'h11223344);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h11223344, 1'b0, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
